sram_controller: RTL
====================

# sram_controller

Bridges the 32-bit memory stage of the pipeline to the 16-bit asynchronous SRAM device. Each 32-bit read or write becomes two 16-bit SRAM accesses, low half first. The block deasserts `ready` for the whole transaction so the pipeline freezes, and it drives all SRAM control, address and data pins.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 2: idle padding cycles after the two SRAM accesses. Legal range 0..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_en`  in  1  write request. Held stable until `ready`=1.
- `rd_en`  in  1  read request. Held stable until `ready`=1.
- `address`  in  32  byte address, word-aligned.
- `writeData`  in  32  write data.
- `readData`  out  32  read result, registered.
- `ready`  out  1  1 when idle with no request, or when the transaction completes. 0 otherwise.
- `SRAM_DQ`  inout  16  data bus. Driven only during write accesses, otherwise `16'bz`.
- `SRAM_ADDR`  out  18  SRAM halfword address.
- `SRAM_WE_N`  out  1  write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied 0.

## Operation
- States: IDLE, LOW, HIGH, WAIT, DONE. A 3-bit counter `wcnt` is used in WAIT.
- IDLE:
  - Request (`wr_en|rd_en`) seen: latch `address`, `writeData` and `is_write = wr_en`, then go to LOW.
  - If both `wr_en` and `rd_en` are high, write wins.
- LOW: go to HIGH.
- HIGH:
  - Go to WAIT with `wcnt`=0 if `WAIT_CYCLES`>0.
  - Go directly to DONE if `WAIT_CYCLES`=0.
- WAIT: increment `wcnt`. When `wcnt`=`WAIT_CYCLES`-1, go to DONE.
- DONE: go to IDLE unconditionally. A request still asserted in the following IDLE cycle starts a new transaction.
- Address mapping:
  - `off = latched_address - BASE_ADDR` (32-bit, modulo 2^32).
  - `word = off[18:2]`.
  - In LOW, `SRAM_ADDR = {word,1'b0}`. In HIGH, `SRAM_ADDR = {word,1'b1}`. In all other states, `SRAM_ADDR` = 0.
  - `off[1:0]` and `off[31:19]` are ignored.
- Write:
  - In LOW and HIGH, `SRAM_WE_N`=0.
  - `SRAM_DQ` = `wdata[15:0]` in LOW, `wdata[31:16]` in HIGH.
- Read:
  - `SRAM_WE_N`=1 and `SRAM_DQ`=Z.
  - `readData[15:0]` is loaded from `SRAM_DQ` at the edge ending LOW.
  - `readData[31:16]` is loaded from `SRAM_DQ` at the edge ending HIGH.
- `readData` holds its value until the next read overwrites it. Writes never change `readData`.
- `ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE when `wr_en|rd_en`=0.
  - 0 otherwise.

## Timing
- Reset values:
  - state IDLE, `wcnt`=0, `readData`=0.
  - `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z.
  - `ready` = `~(wr_en|rd_en)`.
- Request first seen in IDLE at cycle T:
  - LOW at T+1, HIGH at T+2.
  - DONE at T+3+`WAIT_CYCLES`. This is T+5 at the default.
- `ready`=0 from T through T+2+`WAIT_CYCLES`, and `ready`=1 for exactly one cycle in DONE.
- Read data is stable in DONE and after.
- Back-to-back transactions: a request held after DONE restarts at T+4+`WAIT_CYCLES`. There is one IDLE cycle between transactions, and `ready`=0 in that cycle.
- Request inputs are sampled only in IDLE. Changes in any other state are ignored.
- SRAM data has up to 5 time units of output delay. It must be settled before the sampling edge, so the clock period must be at least 10 time units.
- Reset mid-transaction:
  - Return to IDLE on the next edge.
  - `SRAM_WE_N`=1 and DQ released that same edge.
  - `readData` cleared to 0.
  - A partially written word is left as is.

## Test plan
- Write 0xDEADBEEF to `address` 1024, default parameters:
  - SRAM[0]=0xBEEF and SRAM[1]=0xDEAD.
  - `ready` is 0 for cycles T..T+4 and 1 at T+5.
- Read `address` 1024 after that write:
  - `readData`=0xDEADBEEF in DONE at T+5.
  - `SRAM_ADDR` is 0 in LOW and 1 in HIGH.
- Write 0x12345678 to 1028, then read it back:
  - SRAM[2]=0x5678 and SRAM[3]=0x1234.
  - The read returns 0x12345678.
  - `SRAM_DQ` is Z throughout the read.
- `wr_en`=`rd_en`=1 with `address`=1032 and `writeData`=0xCAFEF00D:
  - A write occurs: SRAM[4]=0xF00D and SRAM[5]=0xCAFE.
  - `readData` is unchanged.
- Assert `rst` in HIGH during a write of 0xAAAA5555 to 1036:
  - Next cycle: IDLE, `SRAM_WE_N`=1, DQ=Z, `readData`=0.
  - SRAM[6]=0x5555 was already written.
  - A subsequent full write/read of the same address completes normally.
- `WAIT_CYCLES`=0 with `rd_en` held across two reads:
  - DONE at T+3 and T+7.
  - `ready` is high only in those cycles.
- No request: `ready` stays 1 and `SRAM_WE_N` stays 1 indefinitely.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges a 32-bit memory-stage request onto a 16-bit asynchronous SRAM as
// two halfword accesses (low half first), stalling the pipeline via ready.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] WCNT_LAST = 3'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  wcnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        is_write;
    logic        req;
    logic [31:0] off;
    logic [16:0] word;
    logic [14:0] off_unused;
    logic        dq_oe;
    logic [15:0] dq_out;

    assign req = wr_en | rd_en;

    // Only off[18:2] selects the SRAM word; the remaining bits are dropped.
    assign off        = addr_q - BASE_ADDR;
    assign word       = off[18:2];
    assign off_unused = {off[31:19], off[1:0]};

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            readData <= '0;
        end else begin
            state <= state_next;
            if (state == S_HIGH)
                wcnt <= '0;
            else if (state == S_WAIT)
                wcnt <= wcnt + 3'd1;
            if (!is_write && state == S_LOW)
                readData[15:0] <= SRAM_DQ;
            if (!is_write && state == S_HIGH)
                readData[31:16] <= SRAM_DQ;
        end
    end

    // NOTE: request registers carry no reset; they are loaded before any use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            addr_q   <= address;
            wdata_q  <= writeData;
            is_write <= wr_en;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = S_LOW;
            S_LOW:   state_next = S_HIGH;
            S_HIGH:  state_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            S_WAIT:  if (wcnt == WCNT_LAST) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            S_LOW: begin
                SRAM_ADDR = {word, 1'b0};
                SRAM_WE_N = ~is_write;
                dq_oe     = is_write;
                dq_out    = wdata_q[15:0];
            end
            S_HIGH: begin
                SRAM_ADDR = {word, 1'b1};
                SRAM_WE_N = ~is_write;
                dq_oe     = is_write;
                dq_out    = wdata_q[31:16];
            end
            default: ;
        endcase
        ready = (state == S_DONE) || (state == S_IDLE && !req);
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule
